// File: rtl/risc_pkg.sv
// Shared definitions for the 13-bit RISC core: widths, the NOP word, the HALT
// opcode and its field position, and the fetch sequencer state encoding.
package risc_pkg;

    localparam int PC_W    = 5;
    localparam int INSTR_W = 13;

    localparam int OPC_HI = 12;
    localparam int OPC_LO = 9;

    localparam logic [INSTR_W-1:0]     NOP     = 13'h0000;
    localparam logic [OPC_HI-OPC_LO:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_VALID  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[OPC_HI:OPC_LO] == OP_HALT;
    endfunction

endpackage

// File: rtl/risc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues req/ack instruction reads, buffers one
// word for decode, follows execute redirects and parks on HALT.
module risc_fetch_ctrl
    import risc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [PC_W-1:0]    pc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_addr,
    output logic               halted
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [INSTR_W-1:0] r_ir;
    logic [INSTR_W-1:0] w_ir_nxt;
    logic               r_ir_valid;
    logic               w_ir_valid_nxt;
    logic               r_mem_req;
    logic               r_halted;
    logic               w_redirect;

    // Redirect outranks ack and ir_ready; IDLE is the only state that ignores it.
    assign w_redirect = redirect_valid && (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_ir_nxt       = r_ir;
        w_ir_valid_nxt = r_ir_valid;

        if (w_redirect) begin
            w_pc_nxt       = redirect_addr;
            w_ir_nxt       = NOP;
            w_ir_valid_nxt = 1'b0;
            w_state_nxt    = ST_REQ;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        w_state_nxt = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        w_ir_nxt       = mem_rdata;
                        w_ir_valid_nxt = 1'b1;
                        w_pc_nxt       = r_pc + PC_W'(1);
                        w_state_nxt    = ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (ir_ready) begin
                        w_ir_nxt       = NOP;
                        w_ir_valid_nxt = 1'b0;
                        if (is_halt(r_ir)) begin
                            w_state_nxt = ST_HALTED;
                        end else if (!run) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_REQ;
                        end
                    end
                end
                ST_HALTED: begin
                    w_state_nxt = ST_HALTED;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Request and halt flags are registered from the next state so every output
    // leaves a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_ir       <= NOP;
            r_ir_valid <= 1'b0;
            r_mem_req  <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_ir_valid <= w_ir_valid_nxt;
            r_mem_req  <= (w_state_nxt == ST_REQ);
            r_halted   <= (w_state_nxt == ST_HALTED);
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_pc;
    assign pc       = r_pc;
    assign ir       = r_ir;
    assign ir_valid = r_ir_valid;
    assign halted   = r_halted;

endmodule

// File: tb/tb_risc_fetch_ctrl.sv
// Scoreboard bench for risc_fetch_ctrl: directed scenarios followed by random
// traffic, checked against a transaction-level model of the fetch rules.
module tb_risc_fetch_ctrl;
    import risc_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               run = 1'b0;
    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic               mem_ack = 1'b0;
    logic [INSTR_W-1:0] mem_rdata = '0;
    logic [INSTR_W-1:0] ir;
    logic               ir_valid;
    logic               ir_ready = 1'b0;
    logic [PC_W-1:0]    pc;
    logic               redirect_valid = 1'b0;
    logic [PC_W-1:0]    redirect_addr = '0;
    logic               halted;

    risc_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .ir             (ir),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [INSTR_W-1:0] mem [32];

    // Reference model: what the fetch unit is doing, not how.
    int                 m_pc;
    logic [INSTR_W-1:0] m_word;
    bit                 m_have;
    bit                 m_fetch;
    bit                 m_halt;
    logic [INSTR_W-1:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_word = NOP; m_have = 0; m_fetch = 0; m_halt = 0;
    endtask

    task automatic model_update(input bit r, input bit ack, input bit rdy,
                                input bit redir, input int raddr);
        bit idle;
        idle = !(m_fetch || m_have || m_halt);
        if (redir && !idle) begin
            m_pc = raddr; m_have = 0; m_word = NOP; m_halt = 0; m_fetch = 1;
        end else if (m_fetch && ack) begin
            m_word = mem[m_pc]; m_have = 1; m_fetch = 0;
            m_pc = (m_pc + 1) % 32;
        end else if (m_have && rdy) begin
            exp_q.push_back(m_word);
            m_have = 0;
            if (m_word[12:9] == 4'hF) m_halt = 1;
            else if (r) m_fetch = 1;
            m_word = NOP;
        end else if (idle && r) begin
            m_fetch = 1;
        end
    endtask

    task automatic check_outputs();
        chk("mem_req", 32'(mem_req), 32'(m_fetch));
        chk("pc", 32'(pc), 32'(m_pc));
        chk("ir_valid", 32'(ir_valid), 32'(m_have));
        chk("ir", 32'(ir), 32'(m_have ? m_word : NOP));
        chk("halted", 32'(halted), 32'(m_halt));
        if (m_fetch) chk("mem_addr", 32'(mem_addr), 32'(m_pc));
    endtask

    // One cycle: check what the DUT shows now, then apply the next inputs.
    task automatic step(input bit r, input bit ack, input bit rdy,
                        input bit redir, input int raddr);
        @(negedge clk);
        check_outputs();
        run            = r;
        mem_ack        = ack;
        mem_rdata      = ack ? mem[m_pc] : INSTR_W'($urandom);
        ir_ready       = rdy;
        redirect_valid = redir;
        redirect_addr  = PC_W'(raddr);
        model_update(r, ack, rdy, redir, raddr);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 13'h1FFF;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_ir", 32'(ir), 32'(NOP));
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        #1;
        mem_ack = 1'b0;
        run = 1'b0; ir_ready = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [INSTR_W-1:0] rand_word(input bit allow_halt);
        logic [INSTR_W-1:0] w;
        w = INSTR_W'($urandom);
        if (!allow_halt && w[12:9] == 4'hF) w[12] = 1'b0;
        return w;
    endfunction

    // Monitor: each word decode actually takes is matched against the model's.
    initial begin
        logic [INSTR_W-1:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && ir_valid && ir_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    chk("consume_unexpected", 32'(ir), 32'h0001_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("consume_ir", 32'(ir), 32'(e));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = rand_word(1'b0);
        mem[0] = 13'h0101;
        mem[1] = 13'h0202;
        model_reset();
        apply_reset();

        // Back-to-back fetch with zero-wait memory, then stop.
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Decode stalls for 5 cycles after the first fetch.
        apply_reset();
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);

        // Run across the top of the address space.
        for (int i = 0; i < 72; i++) step(1, 1, 1, 0, 0);

        // HALT at address 4, then leave via redirect to 9.
        mem[4] = 13'h1E00;
        step(1, 0, 0, 1, 4);
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0);
        mem[9] = 13'h0ABC;
        step(1, 0, 0, 1, 9);

        // Redirect to 17 in the same cycle as an ack: the data is dropped.
        step(1, 1, 1, 1, 17);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);

        // Reset while a request is outstanding, with a late ack during reset.
        step(1, 0, 0, 0, 0);
        apply_reset();
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // Random traffic, including HALT words and redirects in every state.
        for (int i = 0; i < 32; i++) mem[i] = rand_word($urandom_range(0, 7) == 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0,
                 int'($urandom_range(0, 31)));
        end
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
